// File: rtl/dadda_divider_pkg.sv
// Shared constants and FSM state type for the sequential 32/16 restoring divider.
package dadda_pkg;
  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;
endpackage

// File: rtl/dadda_divider_if.sv
// Start/busy/done handshake and operand/result bundle of the divider.
interface dadda_divider_if;
  import dadda_pkg::*;

  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 ovf;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, ovf
  );
endinterface

// File: rtl/dadda_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract
// the divisor when it fits and report the resulting quotient bit.
module dadda_div_step
  import dadda_pkg::*;
(
  input  logic [WIDTH:0]   pr_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   pr_o,
  output logic             q_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  // A restored remainder is always below the divisor, so its MSB is never set.
  logic           unused_pr_msb;

  assign unused_pr_msb = pr_i[WIDTH];
  assign shifted       = {pr_i[WIDTH-1:0], bit_i};
  assign diff          = shifted - {1'b0, divisor_i};
  assign q_o           = (shifted >= {1'b0, divisor_i});
  assign pr_o          = q_o ? diff : shifted;
endmodule

// File: rtl/dadda_divider.sv
// Sequential 32/16 unsigned restoring divider, one quotient bit per clock, 17-cycle latency.
// Optional DADDA_DIV_OVF_CHECK_EN flags divide-by-zero / quotient overflow early via ovf.
module dadda_divider
  import dadda_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  dadda_divider_if.slave  dif
);
  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   pr_q, pr_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH:0]   pr_nxt;
  logic             q_bit;
`ifdef DADDA_DIV_OVF_CHECK_EN
  logic             ovf_q, ovf_d;
  logic             pend_q, pend_d;
`endif

  // lo_q shifts dividend bits out of its top while quotient bits enter at the bottom.
  dadda_div_step u_step (
    .pr_i      (pr_q),
    .bit_i     (lo_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .pr_o      (pr_nxt),
    .q_o       (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef DADDA_DIV_OVF_CHECK_EN
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      lo_q    <= lo_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef DADDA_DIV_OVF_CHECK_EN
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    lo_d    = lo_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef DADDA_DIV_OVF_CHECK_EN
    ovf_d   = ovf_q;
    pend_d  = pend_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (dif.start) begin
          dvs_d   = dif.divisor;
          pr_d    = {1'b0, dif.dividend[2*WIDTH-1:WIDTH]};
          lo_d    = dif.dividend[WIDTH-1:0];
          cnt_d   = CNT_W'(WIDTH);
          state_d = RUN;
`ifdef DADDA_DIV_OVF_CHECK_EN
          // Overflowing operands spend a single RUN cycle so done lands one edge later.
          pend_d  = (dif.divisor == '0) ||
                    (dif.dividend[2*WIDTH-1:WIDTH] >= dif.divisor);
          if (pend_d) cnt_d = CNT_W'(1);
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        pr_d  = pr_nxt;
        lo_d  = {lo_q[WIDTH-2:0], q_bit};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          quo_d   = {lo_q[WIDTH-2:0], q_bit};
          rem_d   = pr_nxt[WIDTH-1:0];
          state_d = DONE;
`ifdef DADDA_DIV_OVF_CHECK_EN
          ovf_d   = pend_q;
          if (pend_q) begin
            quo_d = '1;
            rem_d = '0;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dif.busy      = (state_q == RUN);
  assign dif.done      = (state_q == DONE);
  assign dif.quotient  = quo_q;
  assign dif.remainder = rem_q;
`ifdef DADDA_DIV_OVF_CHECK_EN
  assign dif.ovf       = ovf_q;
`else
  assign dif.ovf       = 1'b0;
`endif
endmodule

// File: tb/tb_dadda_divider.sv
// Scoreboard bench for dadda_divider: issued operations queue their expected results, a monitor checks each done.
module tb_dadda_divider;
  import dadda_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dadda_divider_if dif();

  dadda_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dif   (dif)
  );

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        ovf;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, req, req);
    end
  endtask

  // Reference: plain integer division; overflow response only exists with the check enabled.
  function automatic exp_t model(input logic [31:0] dvd, input logic [15:0] dvs);
    exp_t e;
    logic [31:0] d32;
    d32   = {16'h0, dvs};
    e.acc = 0;
    if (dvs == 16'h0 || dvd >= (d32 << 16)) begin
      e.q = 16'hFFFF; e.r = 16'h0; e.ovf = 1'b1; e.lat = 2;
    end else begin
      e.q = 16'(dvd / d32); e.r = 16'(dvd % d32); e.ovf = 1'b0; e.lat = 17;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && dif.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {31'h0, dif.done}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("quotient",  {16'h0, dif.quotient},  {16'h0, e.q});
        chk("remainder", {16'h0, dif.remainder}, {16'h0, e.r});
        chk("ovf",       {31'h0, dif.ovf},       {31'h0, e.ovf});
        chk("latency",   cyc - e.acc,            e.lat);
        chk("busy_in_done", {31'h0, dif.busy},   32'd0);
      end
    end
  end

  task automatic issue(input logic [31:0] dvd, input logic [15:0] dvs);
    exp_t e;
    int t = 0;
    @(negedge clk);
    while (dif.busy === 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("busy_timeout", {31'h0, dif.busy}, 32'd0);
    dif.start    = 1'b1;
    dif.dividend = dvd;
    dif.divisor  = dvs;
    e     = model(dvd, dvs);
    e.acc = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    dif.start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain", exp_q.size(), 32'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"},  {31'h0, dif.busy},      32'd0);
    chk({tag, "_done"},  {31'h0, dif.done},      32'd0);
    chk({tag, "_quo"},   {16'h0, dif.quotient},  32'd0);
    chk({tag, "_rem"},   {16'h0, dif.remainder}, 32'd0);
    chk({tag, "_ovf"},   {31'h0, dif.ovf},       32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] dvs, qq, rr;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;

    // Directed cases, issued back to back (second start lands in the DONE cycle).
    issue(32'd549760785, 16'd23415);
    issue(32'd241, 16'd10);
    issue(32'd0, 16'd34543);
    drain();

`ifdef DADDA_DIV_OVF_CHECK_EN
    issue(32'h0001_0000, 16'd1);
    issue(32'd5, 16'd0);
    drain();
`endif

    // Start pulsed mid-RUN must be ignored.
    issue(32'd1000000, 16'd977);
    repeat (5) @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = 32'd12345;
    dif.divisor  = 16'd7;
    @(negedge clk);
    dif.start = 1'b0;
    drain();
    repeat (20) @(negedge clk);

    // Reset mid-operation aborts with all outputs cleared and no done.
    issue(32'd77777777, 16'd4321);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(32'd77777777, 16'd4321);
    drain();

    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 0) dvs = 16'($urandom_range(15, 1));
      else            dvs = 16'($urandom_range(65535, 1));
      qq = 16'($urandom_range(65535, 0));
      rr = 16'($urandom_range(int'(dvs) - 1, 0));
      issue({16'h0, qq} * {16'h0, dvs} + {16'h0, rr}, dvs);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
